mysystem_sysid_checker: RTL and testbench
=========================================

# mysystem_sysid_checker

Avalon-MM read master that queries the system ID slave and checks it against compile-time expected values. It reads the ID word at address 0, then the timestamp word at address 1, and reports pass/fail and timeout status. It sits beside the boot/reset controller and connects through the interconnect to the sysid control slave, so software or a supervisor can detect a mismatched FPGA image.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_0000, value required at address 0
- EXPECTED_TS, 32'h5748_B343 (1464382275), value required at address 1
- TIMEOUT_CYCLES, 255, maximum cycles from request assertion to readdatavalid; 1..65535

Ports:
- clock  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a check; sampled only in IDLE
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; request held while high
- avm_readdata  in  32  read data, valid with avm_readdatavalid
- avm_readdatavalid  in  1  read response strobe
- busy  out  1  check in progress
- done  out  1  one-cycle pulse at end of every check (pass, fail or timeout)
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word
- id_ok  out  1  id_value == EXPECTED_ID
- ts_ok  out  1  ts_value == EXPECTED_TS
- timeout_err  out  1  last check aborted on timeout
- pass  out  1  id_ok & ts_ok & !timeout_err

## Operation
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
- IDLE: start=1 → ID_REQ. Also clears id_ok, ts_ok, timeout_err, pass, id_value and ts_value.
- ID_REQ: avm_read=1, avm_address=0, both held stable while avm_waitrequest=1. On accept (waitrequest=0):
  - readdatavalid also 1 → capture, go to TS_REQ;
  - else → ID_WAIT.
- ID_WAIT: avm_read=0. On readdatavalid, capture avm_readdata into id_value → TS_REQ.
- TS_REQ / TS_WAIT: same as ID_REQ / ID_WAIT, with address 1 and capture into ts_value → FINISH.
- FINISH: set id_ok, ts_ok and pass from the captured values. Pulse done. → IDLE.
- Exactly one outstanding read at any time. No pipelining.
- Timeout: the counter clears on entry to ID_REQ and TS_REQ and increments every cycle in REQ/WAIT. When count == TIMEOUT_CYCLES with no readdatavalid:
  - drop avm_read;
  - set timeout_err=1, leave remaining ok flags 0;
  - → FINISH.
- A readdatavalid arriving in the same cycle the count reaches the limit wins: data is captured and no timeout is raised.
- readdatavalid in IDLE or FINISH is ignored.
- start while busy is ignored; it is not queued.
- Comparisons are full 32-bit equality.

## Timing
- Reset: state IDLE and every output 0, including avm_address, avm_read, busy, done, id_value, ts_value, all flags and pass.
- Reset asserted mid-check: the block returns to IDLE immediately. avm_read is deasserted asynchronously. Any response still pending afterwards is ignored.
- busy=1 from the cycle after start is sampled until the FINISH cycle, inclusive.
- Zero-wait, same-cycle-response slave: start sampled at cycle 0 → avm_read at cycles 1 (addr 0) and 2 (addr 1) → done and flags at cycle 3. Minimum latency 3 cycles.
- Each waitrequest cycle or readdatavalid delay cycle adds exactly one cycle.
- Result flags hold their values from FINISH until the next accepted start.

## Configuration
- SYSID_CHECK_AUTOSTART_EN
  - Defined: a check starts automatically in the first cycle after reset deassertion, as if start=1. It occurs once per reset. Later checks still require start.
  - Undefined: checks run only on start.

## Structure
- Package sysid_check_pkg holds:
  - the FSM state enum;
  - address constants SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - counter width derived from the TIMEOUT_CYCLES range, 16 bits.
- Sub-module sysid_timeout_counter: clear/enable inputs, terminal-count output at TIMEOUT_CYCLES, asynchronous active-high reset.
- Everything else lives in the top module.

## Test plan
- Zero-wait slave returning 0 / 32'h5748B343, start pulse → done at cycle 3, id_ok=1, ts_ok=1, pass=1, timeout_err=0.
- Slave returning ts 32'h5748B344 with waitrequest=1 for 2 cycles per read → avm_address and avm_read held stable during stall, ts_ok=0, pass=0, done at cycle 7.
- Slave that never asserts readdatavalid, TIMEOUT_CYCLES=8 → avm_read dropped, timeout_err=1, pass=0, done 9 cycles after the first request.
- start pulsed while busy, plus a stray readdatavalid in IDLE → only one check runs, no data captured outside the check.
- Reset asserted while in TS_WAIT → all outputs 0 immediately. A late readdatavalid is ignored, and a new start completes normally.
- With SYSID_CHECK_AUTOSTART_EN defined and start held 0 → one check follows reset release with done and pass=1, and no second check occurs.

Source files
------------

// File: rtl/mysystem_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// sysid slave word addresses and the timeout counter width.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_FINISH  = 3'd5
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // TIMEOUT_CYCLES is limited to 1..65535, so 16 bits always hold the limit.
  localparam int SYSID_CNT_W = 16;

endpackage

// File: rtl/mysystem_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the sysid slave.
// Handshake: a read is accepted on a cycle with read=1 and waitrequest=0;
// address/read stay stable while waitrequest=1; readdata is valid only in
// cycles with readdatavalid=1, which may coincide with the accept cycle.
interface mysystem_sysid_checker_if;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface

// File: rtl/mysystem_sysid_checker_timeout.sv
// Per-read timeout counter: cleared at each new request, counts while a read
// is outstanding and saturates at LIMIT, where tc is raised.
module sysid_timeout_counter
  import sysid_check_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [SYSID_CNT_W-1:0] LIMIT_C = SYSID_CNT_W'(LIMIT);

  logic [SYSID_CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mysystem_sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and compares
// them with EXPECTED_ID/EXPECTED_TS. Define SYSID_CHECK_AUTOSTART_EN to run one
// check automatically after every reset release.
module mysystem_sysid_checker
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5748_B343,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  mysystem_sysid_checker_if.master        avm,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     id_value,
  output logic [31:0]                     ts_value,
  output logic                            id_ok,
  output logic                            ts_ok,
  output logic                            timeout_err,
  output logic                            pass,
  output sysid_state_e                    state_dbg
);

  sysid_state_e state_q;
  logic         read_q;
  logic         addr_q;
  logic         busy_q;
  logic         done_q;
  logic         id_ok_q;
  logic         ts_ok_q;
  logic         tmo_q;
  logic         pass_q;
  logic [31:0]  id_q;
  logic [31:0]  ts_q;

  logic start_eff;
  logic accept;
  logic rsp;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

`ifdef SYSID_CHECK_AUTOSTART_EN
  // High only in the first cycle after reset release: one implicit start.
  logic auto_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) auto_q <= 1'b1;
    else       auto_q <= 1'b0;
  end
  assign start_eff = start | auto_q;
`else
  assign start_eff = start;
`endif

  assign accept = avm.read && !avm.waitrequest;
  assign rsp    = avm.readdatavalid;

  // Clear on every entry into ID_REQ or TS_REQ.
  assign cnt_clr = ((state_q == ST_IDLE)    && start_eff)   ||
                   ((state_q == ST_ID_REQ)  && accept && rsp) ||
                   ((state_q == ST_ID_WAIT) && rsp);
  assign cnt_en  = (state_q == ST_ID_REQ) || (state_q == ST_ID_WAIT) ||
                   (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);

  sysid_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      read_q  <= 1'b0;
      addr_q  <= SYSID_ADDR_ID;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_eff) begin
            state_q <= ST_ID_REQ;
            read_q  <= 1'b1;
            addr_q  <= SYSID_ADDR_ID;
            busy_q  <= 1'b1;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            tmo_q   <= 1'b0;
            pass_q  <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
          end
        end
        ST_ID_REQ, ST_ID_WAIT: begin
          // A response in the limit cycle still counts as a good read.
          if ((state_q == ST_ID_WAIT && rsp) || (accept && rsp)) begin
            id_q    <= avm.readdata;
            state_q <= ST_TS_REQ;
            read_q  <= 1'b1;
            addr_q  <= SYSID_ADDR_TS;
          end else if (cnt_tc) begin
            read_q  <= 1'b0;
            tmo_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else if (accept) begin
            read_q  <= 1'b0;
            state_q <= ST_ID_WAIT;
          end
        end
        ST_TS_REQ, ST_TS_WAIT: begin
          if ((state_q == ST_TS_WAIT && rsp) || (accept && rsp)) begin
            ts_q    <= avm.readdata;
            read_q  <= 1'b0;
            id_ok_q <= (id_q == EXPECTED_ID);
            ts_ok_q <= (avm.readdata == EXPECTED_TS);
            pass_q  <= (id_q == EXPECTED_ID) && (avm.readdata == EXPECTED_TS);
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else if (cnt_tc) begin
            read_q  <= 1'b0;
            tmo_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else if (accept) begin
            read_q  <= 1'b0;
            state_q <= ST_TS_WAIT;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign avm.read    = read_q;
  assign avm.address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = tmo_q;
  assign pass        = pass_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mysystem_sysid_checker.sv
// Directed bench for mysystem_sysid_checker with a small configurable sysid
// slave (stall cycles, response latency, returned words), TIMEOUT_CYCLES=8.
module tb_mysystem_sysid_checker;
  import sysid_check_pkg::*;

  localparam logic [31:0] GOOD_TS = 32'h5748_B343;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clock = ~clock;

  mysystem_sysid_checker_if avm ();

  logic         busy, done, id_ok, ts_ok, timeout_err, pass;
  logic [31:0]  id_value, ts_value;
  sysid_state_e dbg;

  mysystem_sysid_checker #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .avm         (avm),
    .busy        (busy),
    .done        (done),
    .id_value    (id_value),
    .ts_value    (ts_value),
    .id_ok       (id_ok),
    .ts_ok       (ts_ok),
    .timeout_err (timeout_err),
    .pass        (pass),
    .state_dbg   (dbg)
  );

  // ---------------- sysid slave model ----------------
  int          cfg_wait = 0;
  int          cfg_lat  = 0;
  logic [31:0] id_word  = 32'h0;
  logic [31:0] ts_word  = GOOD_TS;
  logic        m_wr = 1'b0, m_rdv = 1'b0, m_pend = 1'b0;
  logic [31:0] m_data = 32'h0, m_pend_data = 32'h0;
  int          m_stall_left = 0, m_lat_left = 0;
  logic        f_rdv = 1'b0;
  logic [31:0] f_data = 32'h0;

  assign avm.waitrequest   = m_wr;
  assign avm.readdatavalid = m_rdv | f_rdv;
  assign avm.readdata      = f_rdv ? f_data : m_data;

  always @(negedge clock) begin
    m_rdv = 1'b0;
    m_wr  = 1'b0;
    if (m_pend) begin
      if (m_lat_left == 0) begin
        m_rdv  = 1'b1;
        m_data = m_pend_data;
        m_pend = 1'b0;
      end else begin
        m_lat_left--;
      end
    end else if (avm.read) begin
      if (m_stall_left > 0) begin
        m_wr = 1'b1;
        m_stall_left--;
      end else begin
        m_stall_left = cfg_wait;
        if (cfg_lat == 0) begin
          m_rdv  = 1'b1;
          m_data = avm.address ? ts_word : id_word;
        end else begin
          m_pend      = 1'b1;
          m_lat_left  = cfg_lat - 1;
          m_pend_data = avm.address ? ts_word : id_word;
        end
      end
    end else begin
      m_stall_left = cfg_wait;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic rd_s [0:63];
  logic ad_s [0:63];
  logic bz_s [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic setup(input int w, input int l, input logic [31:0] idw, input logic [31:0] tsw);
    cfg_wait = w;
    cfg_lat  = l;
    id_word  = idw;
    ts_word  = tsw;
    repeat (2) @(negedge clock);
  endtask

  // Called at a negedge; start is sampled at the next posedge (cycle 0).
  // done_n is the cycle number in which done was seen, -1 if never.
  task automatic run_check(input int pulse_n, output int done_n);
    done_n = -1;
    start  = 1'b1;
    for (int n = 1; n < 64; n++) begin
      @(negedge clock);
      start   = (n == pulse_n);
      rd_s[n] = avm.read;
      ad_s[n] = avm.address;
      bz_s[n] = busy;
      if (done) begin
        done_n = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  int dn;
  int cnt;

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clock);
    chk("rst_read",  32'(avm.read), 32'd0);
    chk("rst_addr",  32'(avm.address), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_idv",   id_value, 32'd0);
    chk("rst_tsv",   ts_value, 32'd0);
    chk("rst_flags", {28'd0, id_ok, ts_ok, timeout_err, pass}, 32'd0);
    chk("rst_state", 32'(dbg), 32'(ST_IDLE));
    reset = 1'b0;

`ifdef SYSID_CHECK_AUTOSTART_EN
    dn = -1;
    for (int n = 1; n < 20; n++) begin
      @(negedge clock);
      if (done) begin
        dn = n;
        break;
      end
    end
    chk("auto_done_cycle", 32'(dn), 32'd3);
    chk("auto_pass", 32'(pass), 32'd1);
    cnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (busy) cnt++;
    end
    chk("auto_no_second", 32'(cnt), 32'd0);
`else
    repeat (5) @(negedge clock);
    chk("noauto_busy",  32'(busy), 32'd0);
    chk("noauto_state", 32'(dbg), 32'(ST_IDLE));
`endif

    // ---- A: zero-wait slave, good words ----
    setup(0, 0, 32'h0, GOOD_TS);
    chk("a_busy_pre", 32'(busy), 32'd0);
    run_check(0, dn);
    chk("a_done_cycle", 32'(dn), 32'd3);
    chk("a_req1", {30'd0, rd_s[1], ad_s[1]}, 32'b10);
    chk("a_req2", {30'd0, rd_s[2], ad_s[2]}, 32'b11);
    chk("a_busy1", 32'(bz_s[1]), 32'd1);
    chk("a_flags", {28'd0, id_ok, ts_ok, timeout_err, pass}, 32'b1101);
    chk("a_busy_fin", 32'(busy), 32'd1);
    chk("a_tsv", ts_value, GOOD_TS);
    @(negedge clock);
    chk("a_after", {30'd0, busy, done}, 32'd0);
    chk("a_hold", {28'd0, id_ok, ts_ok, timeout_err, pass}, 32'b1101);

    // ---- B: 2 stall cycles per read, wrong timestamp ----
    setup(2, 0, 32'h0, 32'h5748_B344);
    run_check(0, dn);
    chk("b_done_cycle", 32'(dn), 32'd7);
    chk("b_id_hold", {26'd0, rd_s[1], ad_s[1], rd_s[2], ad_s[2], rd_s[3], ad_s[3]}, 32'b101010);
    chk("b_ts_hold", {26'd0, rd_s[4], ad_s[4], rd_s[5], ad_s[5], rd_s[6], ad_s[6]}, 32'b111111);
    chk("b_flags", {28'd0, id_ok, ts_ok, timeout_err, pass}, 32'b1000);
    chk("b_tsv", ts_value, 32'h5748_B344);

    // ---- C: slave stalls forever -> timeout ----
    setup(1000, 0, 32'h0, GOOD_TS);
    run_check(0, dn);
    chk("c_done_cycle", 32'(dn), 32'd10);
    chk("c_read_c9", 32'(rd_s[9]), 32'd1);
    chk("c_read_drop", 32'(avm.read), 32'd0);
    chk("c_flags", {28'd0, id_ok, ts_ok, timeout_err, pass}, 32'b0010);

    // ---- D: response exactly at the limit wins ----
    setup(0, 8, 32'h0, GOOD_TS);
    run_check(0, dn);
    chk("d_done_cycle", 32'(dn), 32'd19);
    chk("d_flags", {28'd0, id_ok, ts_ok, timeout_err, pass}, 32'b1101);

    // ---- E: response one cycle past the limit times out, late data ignored ----
    setup(0, 9, 32'hCAFE_0001, GOOD_TS);
    run_check(0, dn);
    chk("e_done_cycle", 32'(dn), 32'd10);
    chk("e_flags", {28'd0, id_ok, ts_ok, timeout_err, pass}, 32'b0010);
    repeat (3) @(negedge clock);
    chk("e_idv_ignored", id_value, 32'd0);

    // ---- F: start while busy ignored, stray response in IDLE ignored ----
    setup(0, 1, 32'h0, GOOD_TS);
    run_check(2, dn);
    chk("f_done_cycle", 32'(dn), 32'd5);
    cnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (busy || done) cnt++;
    end
    chk("f_single_check", 32'(cnt), 32'd0);
    f_data = 32'h0BAD_F00D;
    f_rdv  = 1'b1;
    @(negedge clock);
    f_rdv  = 1'b0;
    @(negedge clock);
    chk("f_idv", id_value, 32'd0);
    chk("f_tsv", ts_value, GOOD_TS);
    chk("f_pass", {30'd0, pass, busy}, 32'b10);

    // ---- G: reset in TS_WAIT, late response, then a clean check ----
    setup(0, 3, 32'hA5A5_0001, GOOD_TS);
    start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("g_state", 32'(dbg), 32'(ST_TS_WAIT));
    chk("g_idv_pre", id_value, 32'hA5A5_0001);
    reset = 1'b1;
    #1;
    chk("g_rst_outs", {29'd0, avm.read, busy, done}, 32'd0);
    chk("g_rst_idv", id_value, 32'd0);
    chk("g_rst_state", 32'(dbg), 32'(ST_IDLE));
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("g_late_ignored", {id_value[15:0], ts_value[15:0]}, 32'd0);
    chk("g_idle", {31'd0, busy}, 32'd0);
    setup(0, 0, 32'h0, GOOD_TS);
    run_check(0, dn);
    chk("g_done_cycle", 32'(dn), 32'd3);
    chk("g_flags", {28'd0, id_ok, ts_ok, timeout_err, pass}, 32'b1101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so a hung DUT still ends the run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
